stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_pkg.sv | 22 ++
 rtl/stopwatch_tick.sv | 39 +++
 rtl/stopwatch_ctrl.sv | 133 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } sw_state_e;

    localparam logic [6:0] CS_MAX     = 7'd99;
    localparam logic [5:0] SEC_MAX    = 6'd59;
    localparam logic [6:0] MIN_MAX    = 7'd99;
    localparam logic [5:0] POINT_MASK = 6'b010100;

    // Packs MM:SS.CC into the decimal-weighted binary value the display expects.
    function automatic logic [19:0] to_display(input logic [6:0] mins,
                                               input logic [5:0] secs,
                                               input logic [6:0] cents);
        return 20'(mins) * 20'd10000 + 20'(secs) * 20'd100 + 20'(cents);
    endfunction

endpackage

// File: rtl/stopwatch_tick.sv
// 10 ms prescaler: counts only while run, holds otherwise, zeroed by clr.
module stopwatch_tick
    import stopwatch_pkg::*;
#(
    parameter int CNT_10MS_MAX = 499_999
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (CNT_10MS_MAX > 0) ? $clog2(CNT_10MS_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_10MS_MAX);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = (cnt_q == CNT_TOP) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = run && (cnt_q == CNT_TOP);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: IDLE/RUN/STOP FSM, cascaded cs/sec/min counters, display value.
// Optional lap hold is compiled in with `define STOPWATCH_LAP_EN.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CNT_10MS_MAX = 499_999
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        key_start,
    input  logic        key_clr,
    input  logic        key_lap,
    output logic [19:0] data,
    output logic [5:0]  point,
    output logic        sign,
    output logic        seg_en,
    output sw_state_e   state_dbg
);

    sw_state_e   state_q, state_d;
    logic [6:0]  cs_q, cs_d;
    logic [5:0]  sec_q, sec_d;
    logic [6:0]  min_q, min_d;
    logic [19:0] data_q, data_d;
    logic [5:0]  point_q;
    logic        seg_en_q;
    logic        tick;

    // key_clr also zeroes the prescaler on the same edge it clears the counters.
    stopwatch_tick #(
        .CNT_10MS_MAX(CNT_10MS_MAX)
    ) u_tick (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .run      (state_q == ST_RUN),
        .clr      (key_clr || (state_q == ST_IDLE)),
        .tick     (tick)
    );

    always_comb begin
        state_d = state_q;
        if (key_clr) begin
            state_d = ST_IDLE;
        end else if (key_start) begin
            case (state_q)
                ST_IDLE: state_d = ST_RUN;
                ST_RUN:  state_d = ST_STOP;
                ST_STOP: state_d = ST_RUN;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cs_d  = cs_q;
        sec_d = sec_q;
        min_d = min_q;
        if (key_clr) begin
            cs_d  = '0;
            sec_d = '0;
            min_d = '0;
        end else if (tick) begin
            if (cs_q == CS_MAX) begin
                cs_d = '0;
                if (sec_q == SEC_MAX) begin
                    sec_d = '0;
                    min_d = (min_q == MIN_MAX) ? 7'd0 : min_q + 7'd1;
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end else begin
                cs_d = cs_q + 7'd1;
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic lap_q, lap_d;

    // Leaving RUN always drops the hold; the flag toggles only on a key_lap seen in RUN.
    always_comb begin
        lap_d = lap_q;
        if (state_d != ST_RUN) begin
            lap_d = 1'b0;
        end else if (key_lap && (state_q == ST_RUN)) begin
            lap_d = !lap_q;
        end
        data_d = lap_d ? data_q : to_display(min_q, sec_q, cs_q);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            lap_q <= 1'b0;
        end else begin
            lap_q <= lap_d;
        end
    end
`else
    logic key_lap_unused;
    assign key_lap_unused = key_lap;

    always_comb begin
        data_d = to_display(min_q, sec_q, cs_q);
    end
`endif

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q  <= ST_IDLE;
            cs_q     <= '0;
            sec_q    <= '0;
            min_q    <= '0;
            data_q   <= '0;
            point_q  <= '0;
            seg_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cs_q     <= cs_d;
            sec_q    <= sec_d;
            min_q    <= min_d;
            data_q   <= data_d;
            point_q  <= POINT_MASK;
            seg_en_q <= 1'b1;
        end
    end

    assign data      = data_q;
    assign point     = point_q;
    assign sign      = 1'b0;
    assign seg_en    = seg_en_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with a 5-cycle tick: directed table, wrap sequence, random vs model.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    localparam int CNT_MAX = 4;
    localparam int WRAP    = 600000;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_STOP  = 2;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        key_start = 1'b0;
    logic        key_clr   = 1'b0;
    logic        key_lap   = 1'b0;
    logic [19:0] data;
    logic [5:0]  point;
    logic        sign;
    logic        seg_en;
    sw_state_e   state_dbg;

    int checks = 0;
    int errors = 0;

    stopwatch_ctrl #(
        .CNT_10MS_MAX(CNT_MAX)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .key_start(key_start),
        .key_clr  (key_clr),
        .key_lap  (key_lap),
        .data     (data),
        .point    (point),
        .sign     (sign),
        .seg_en   (seg_en),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    always #5 sys_clk = ~sys_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver / checker tasks ----------------
    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Called at a negedge; applies inputs across one rising edge and returns at the next negedge.
    task automatic drive(input logic r, input logic s, input logic c, input logic l);
        sys_rst_n = r;
        key_start = s;
        key_clr   = c;
        key_lap   = l;
        @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        key_start = 1'b0;
        key_clr   = 1'b0;
        key_lap   = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        rst_n;
        logic        start;
        logic        clr;
        logic        lap;
        int          wait_n;
        int          exp_data;
        sw_state_e   exp_state;
        logic [5:0]  exp_point;
        logic        exp_seg;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic s, input logic c, input logic l, input int w,
                       input int d, input sw_state_e st, input logic [5:0] pt, input logic sg,
                       input string nm);
        vec_t v;
        v.rst_n = r; v.start = s; v.clr = c; v.lap = l; v.wait_n = w;
        v.exp_data = d; v.exp_state = st; v.exp_point = pt; v.exp_seg = sg; v.name = nm;
        vecs.push_back(v);
    endtask

    // ---------------- reference model (time kept as total centiseconds) ----------------
    int         m_t, m_phase, m_mode, m_data;
    logic       m_lap, m_seg;
    logic [5:0] m_point;
    logic [19:0] exp_q[$];

    function automatic int disp(input int t);
        return (t / 6000) * 10000 + ((t / 100) % 60) * 100 + (t % 100);
    endfunction

    function automatic int mode_to_state(input int m);
        if (m == M_RUN)  return 32'(ST_RUN);
        if (m == M_STOP) return 32'(ST_STOP);
        return 32'(ST_IDLE);
    endfunction

    task automatic model_step(input logic r, input logic s, input logic c, input logic l);
        int   nmode;
        logic tk;
        logic nlap;
        if (!r) begin
            m_t = 0; m_phase = 0; m_mode = M_IDLE; m_lap = 1'b0;
            m_data = 0; m_point = 6'd0; m_seg = 1'b0;
        end else begin
            tk    = (m_mode == M_RUN) && (m_phase == CNT_MAX);
            nmode = m_mode;
            if (c) nmode = M_IDLE;
            else if (s) nmode = (m_mode == M_RUN) ? M_STOP : M_RUN;
            nlap = 1'b0;
            if (LAP_EN && nmode == M_RUN) nlap = (l && m_mode == M_RUN) ? !m_lap : m_lap;
            if (!nlap) m_data = disp(m_t);
            if (c) m_t = 0;
            else if (tk) m_t = (m_t + 1) % WRAP;
            if (c || m_mode == M_IDLE) m_phase = 0;
            else if (m_mode == M_RUN) m_phase = tk ? 0 : m_phase + 1;
            m_mode = nmode; m_lap = nlap; m_point = POINT_MASK; m_seg = 1'b1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic r, s, c, l;

        add(1,0,0,0, 0,  0, ST_IDLE, POINT_MASK, 1, "rel");
        add(1,0,0,0,99,  0, ST_IDLE, POINT_MASK, 1, "idle100");
        add(1,1,0,0, 0,  0, ST_RUN,  POINT_MASK, 1, "start");
        add(1,0,0,0,48,  9, ST_RUN,  POINT_MASK, 1, "run49");
        add(1,1,0,0, 0,  9, ST_STOP, POINT_MASK, 1, "stop");
        add(1,0,0,0, 0, 10, ST_STOP, POINT_MASK, 1, "stop_data");
        add(1,0,0,0,29, 10, ST_STOP, POINT_MASK, 1, "stop_hold");
        add(1,1,0,0, 0, 10, ST_RUN,  POINT_MASK, 1, "resume");
        add(1,0,0,0, 1, 10, ST_RUN,  POINT_MASK, 1, "resume2");
        add(1,1,0,0, 0, 10, ST_STOP, POINT_MASK, 1, "stop_mid");
        add(1,0,0,0, 9, 10, ST_STOP, POINT_MASK, 1, "stop_mid_hold");
        add(1,1,0,0, 0, 10, ST_RUN,  POINT_MASK, 1, "resume_mid");
        add(1,0,0,0, 1, 10, ST_RUN,  POINT_MASK, 1, "phase_tick");
        add(1,0,0,0, 0, 11, ST_RUN,  POINT_MASK, 1, "phase_data");
        add(1,1,1,0, 0, 11, ST_IDLE, POINT_MASK, 1, "clr_start");
        add(1,0,0,0, 0,  0, ST_IDLE, POINT_MASK, 1, "clr_data");
        add(1,0,0,0,19,  0, ST_IDLE, POINT_MASK, 1, "clr_hold");
        add(1,1,0,0, 0,  0, ST_RUN,  POINT_MASK, 1, "start2");
        add(1,0,0,0,184,36, ST_RUN,  POINT_MASK, 1, "run185");
        add(1,0,0,0, 0, 37, ST_RUN,  POINT_MASK, 1, "at37");
        add(0,0,0,0, 0,  0, ST_IDLE, 6'd0,       0, "rst_mid");
        add(1,0,0,0, 0,  0, ST_IDLE, POINT_MASK, 1, "rst_rel");
        add(1,0,0,0,29,  0, ST_IDLE, POINT_MASK, 1, "rst_idle");
        add(1,1,0,0, 0,  0, ST_RUN,  POINT_MASK, 1, "start3");
        add(1,0,0,0,99, 19, ST_RUN,  POINT_MASK, 1, "run100");
        add(1,0,0,0, 0, 20, ST_RUN,  POINT_MASK, 1, "at20");
        add(1,0,0,1, 0, 20, ST_RUN,  POINT_MASK, 1, "lap_on");
        add(1,0,0,0,48, LAP_EN ? 20 : 30, ST_RUN, POINT_MASK, 1, "lap_hold");
        add(1,0,0,1, 0, 30, ST_RUN,  POINT_MASK, 1, "lap_off");
        add(1,0,0,0, 3, 31, ST_RUN,  POINT_MASK, 1, "lap_live");

        // reset phase
        repeat (3) @(negedge sys_clk);
        check_val("reset_data",  32'(data),      0);
        check_val("reset_point", 32'(point),     0);
        check_val("reset_sign",  32'(sign),      0);
        check_val("reset_seg",   32'(seg_en),    0);
        check_val("reset_state", 32'(state_dbg), 32'(ST_IDLE));

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].start, vecs[i].clr, vecs[i].lap);
            repeat (vecs[i].wait_n) drive(1'b1, 1'b0, 1'b0, 1'b0);
            check_val({vecs[i].name, "_data"},  32'(data),      32'(vecs[i].exp_data));
            check_val({vecs[i].name, "_state"}, 32'(state_dbg), 32'(vecs[i].exp_state));
            check_val({vecs[i].name, "_point"}, 32'(point),     32'(vecs[i].exp_point));
            check_val({vecs[i].name, "_seg"},   32'(seg_en),    32'(vecs[i].exp_seg));
            check_val({vecs[i].name, "_sign"},  32'(sign),      0);
        end

        // carry chain and wrap: preload 99:59.98 while running
        force dut.cs_q  = 7'd98;
        force dut.sec_q = 6'd59;
        force dut.min_q = 7'd99;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        release dut.cs_q;
        release dut.sec_q;
        release dut.min_q;
        n = 0;
        while (data !== 20'd995999 && n < 20) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            n++;
        end
        check_val("wrap_max",   32'(data),      995999);
        check_val("wrap_state", 32'(state_dbg), 32'(ST_RUN));
        n = 0;
        while (data === 20'd995999 && n < 20) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            n++;
        end
        check_val("wrap_zero",       32'(data),      0);
        check_val("wrap_zero_state", 32'(state_dbg), 32'(ST_RUN));

        // random stimulus against the model, synchronised by a leading reset
        for (int i = 0; i < 4000; i++) begin
            r = (i < 2) ? 1'b0 : ($urandom_range(0, 1499) != 0);
            s = ($urandom_range(0, 29) == 0);
            c = ($urandom_range(0, 299) == 0);
            l = ($urandom_range(0, 19) == 0);
            model_step(r, s, c, l);
            exp_q.push_back(20'(m_data));
            drive(r, s, c, l);
            check_val("rnd_data",  32'(data),      32'(exp_q.pop_front()));
            check_val("rnd_state", 32'(state_dbg), mode_to_state(m_mode));
            check_val("rnd_point", 32'(point),     32'(m_point));
            check_val("rnd_seg",   32'(seg_en),    32'(m_seg));
            check_val("rnd_sign",  32'(sign),      0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
